// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - valid/ready pipeline register with 2-entry skid buffer, stall/flush control and event counters
module pipe_skid_reg #(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cu_flush,
    input  logic              cu_stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;
    logic              in_fire;
    logic              out_fire;

    assign in_ready  = (state != TWO) & ~cu_stall;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready & ~cu_stall;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Falling-edge update keeps timing aligned with the neighbouring stage registers.
    always_ff @(negedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else if (cu_flush) begin
            state <= EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_q <= '0;
                skid_q <= '0;
            end
            if (flush_q != CNT_MAX) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end else begin
            if (out_valid && !out_fire && stall_q != CNT_MAX) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= ONE;
                        main_q <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state  <= TWO;
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // Skid entry is always older than anything upstream, so it moves up first.
                    if (out_fire) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - scoreboard bench for pipe_skid_reg (wide-counter clearing instance and 2-bit-counter retaining instance)
module tb_pipe_skid_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cu_flush = 1'b0;
    logic       cu_stall = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h0;
    logic       out_ready = 1'b0;

    logic        a_in_ready, a_out_valid;
    logic [7:0]  a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall_cnt, a_flush_cnt;

    logic        b_in_ready, b_out_valid;
    logic [7:0]  b_out_data;
    logic [1:0]  b_occ;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    int tests  = 0;
    int errors = 0;

    logic [7:0] q[$];
    int sa = 0, fa = 0, sb = 0, fb = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(8), .CNT_W(16), .CLEAR_ON_FLUSH(1'b1)) dut_a (
        .clk(clk), .reset(reset), .cu_flush(cu_flush), .cu_stall(cu_stall),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_skid_reg #(.DATA_W(8), .CNT_W(2), .CLEAR_ON_FLUSH(1'b0)) dut_b (
        .clk(clk), .reset(reset), .cu_flush(cu_flush), .cu_stall(cu_stall),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy,
                         input logic stall, input logic flush, input logic rst);
        logic m_in_ready, m_out_valid, m_in_fire, m_out_fire;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        cu_stall  = stall;
        cu_flush  = flush;
        reset     = rst;
        #1;
        m_in_ready  = (q.size() < 2) && !stall;
        m_out_valid = (q.size() > 0);
        m_in_fire   = iv && m_in_ready;
        m_out_fire  = m_out_valid && ordy && !stall;
        check("a_in_ready",  32'(a_in_ready),  32'(m_in_ready));
        check("a_out_valid", 32'(a_out_valid), 32'(m_out_valid));
        check("a_occupancy", 32'(a_occ),       32'(q.size()));
        check("b_occupancy", 32'(b_occ),       32'(q.size()));
        check("a_stall_cnt", 32'(a_stall_cnt), 32'(sa));
        check("a_flush_cnt", 32'(a_flush_cnt), 32'(fa));
        check("b_stall_cnt", 32'(b_stall_cnt), 32'(sb));
        check("b_flush_cnt", 32'(b_flush_cnt), 32'(fb));
        if (m_out_valid) begin
            check("a_out_data", 32'(a_out_data), 32'(q[0]));
            check("b_out_data", 32'(b_out_data), 32'(q[0]));
        end
        @(negedge clk);
        #1;
        if (rst) begin
            q.delete();
            sa = 0; fa = 0; sb = 0; fb = 0;
        end else if (flush) begin
            q.delete();
            if (fa < 65535) fa++;
            if (fb < 3) fb++;
        end else begin
            if (m_out_valid && !m_out_fire) begin
                if (sa < 65535) sa++;
                if (sb < 3) sb++;
            end
            if (m_out_fire) void'(q.pop_front());
            if (m_in_fire) q.push_back(id);
        end
    endtask

    initial begin
        // Reset and its output values
        cycle(0, 8'h00, 0, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 0, 0);
        check("reset_out_data", 32'(a_out_data), 32'h0);

        // Full-throughput stream
        cycle(1, 8'h11, 1, 0, 0, 0);
        cycle(1, 8'h22, 1, 0, 0, 0);
        cycle(1, 8'h33, 1, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0, 0);
        check("stream_stall_cnt", 32'(a_stall_cnt), 32'h0);

        // Skid fill and ordered drain
        cycle(1, 8'h0A, 0, 0, 0, 0);
        cycle(1, 8'h0B, 0, 0, 0, 0);
        check("skid_occ", 32'(a_occ), 32'h2);
        check("skid_in_ready", 32'(a_in_ready), 32'h0);
        cycle(1, 8'h0D, 1, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0, 0);
        check("skid_stall_cnt", 32'(a_stall_cnt), 32'h1);

        // Control-unit stall holds everything
        cycle(1, 8'h05, 1, 0, 0, 0);
        cycle(1, 8'h06, 1, 1, 0, 0);
        cycle(1, 8'h07, 1, 1, 0, 0);
        cycle(1, 8'h08, 1, 1, 0, 0);
        check("stall_data_held", 32'(a_out_data), 32'h05);
        check("stall_cnt_plus3", 32'(a_stall_cnt), 32'h4);
        cycle(0, 8'h00, 1, 0, 0, 0);

        // Flush at occupancy 2 with an offered bundle
        cycle(1, 8'h46, 0, 0, 0, 0);
        cycle(1, 8'h47, 0, 0, 0, 0);
        cycle(1, 8'h0C, 0, 0, 1, 0);
        check("flush_a_data_zero", 32'(a_out_data), 32'h0);
        check("flush_b_data_kept", 32'(b_out_data), 32'h46);
        check("flush_out_valid", 32'(a_out_valid), 32'h0);
        check("flush_cnt_one", 32'(a_flush_cnt), 32'h1);
        cycle(0, 8'h00, 1, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0, 0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 30) == 0), 1'b0);
        end

        // 2-bit stall counter saturation
        cycle(0, 8'h00, 0, 0, 0, 1);
        cycle(1, 8'h09, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 0, 0);
        check("b_stall_saturated", 32'(b_stall_cnt), 32'h3);
        check("a_stall_six", 32'(a_stall_cnt), 32'h6);

        // Reset beats a simultaneous flush at occupancy 2
        cycle(1, 8'h0E, 0, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 1, 1);
        cycle(0, 8'h00, 0, 0, 0, 0);
        check("rst_flush_cnt", 32'(a_flush_cnt), 32'h0);
        check("rst_out_valid", 32'(a_out_valid), 32'h0);
        check("rst_out_data", 32'(b_out_data), 32'h0);
        check("rst_in_ready", 32'(a_in_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
